// File: rtl/aes_128_decryptor_iter_pkg.sv
// aes_pkg: AES-128 constants, GF(2^8) arithmetic, S-boxes, key expansion and FSM states.
package aes_pkg;
  localparam int NB = 4;
  localparam int NK = 4;
  localparam int NR = 10;
  localparam logic [10:1][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  typedef enum logic [2:0] {IDLE, KEYEXP, ADDK, ROUND, DONE} fsmStateT;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = '0;
    p = a;
    for (int i = 0; i < 8; i++) begin
      r = b[i] ? r ^ p : r;
      p = xtime(p);
    end
    return r;
  endfunction
  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gfInv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gfInv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction
  function automatic logic [32*NK-1:0] keyExpand(input logic [32*NK-1:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_128_decryptor_iter_inv_round.sv
// aes_inv_round: one combinational inverse round (InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last_round).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [32*NB-1:0] state,
  input  logic [32*NB-1:0] round_key,
  input  logic             last_round,
  output logic [32*NB-1:0] next_state
);
  logic [32*NB-1:0] ark, mixed;
  // byte (row r, column c) sits at bit offset 127-8*(4c+r); row r rotates right by r
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign ark[127-8*(4*c+r) -: 8] = inv_sbox(state[127-8*(4*((c+4-r)%4)+r) -: 8])
                                       ^ round_key[127-8*(4*c+r) -: 8];
      assign mixed[127-8*(4*c+r) -: 8] = gf_mul(8'h0e, ark[127-8*(4*c+r) -: 8])
                                       ^ gf_mul(8'h0b, ark[127-8*(4*c+(r+1)%4) -: 8])
                                       ^ gf_mul(8'h0d, ark[127-8*(4*c+(r+2)%4) -: 8])
                                       ^ gf_mul(8'h09, ark[127-8*(4*c+(r+3)%4) -: 8]);
    end
  end
  assign next_state = last_round ? ark : mixed;
endmodule

// File: rtl/aes_128_decryptor_iter.sv
// aes_128_decryptor_iter: iterative AES-128 InvCipher, one round key / round per clock.
// Define AES_DEC_KEY_CACHE_EN to skip key expansion when the key repeats.
module aes_128_decryptor_iter
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] cipher,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain,
  output logic         busy
);
  if (NUM_ROUNDS != NR) begin : g_badRounds
    $error("aes_128_decryptor_iter: NUM_ROUNDS must be %0d", NR);
  end
  fsmStateT fsm, fsmNext;
  logic [3:0] cnt;
  logic [32*NB-1:0] st, roundOut;
  logic [32*NK-1:0] rk [0:NR];
  logic cacheHit;
  aes_inv_round u_round (
    .state(st),
    .round_key(rk[cnt]),
    .last_round(cnt == 4'd0),
    .next_state(roundOut)
  );
  assign in_ready = fsm == IDLE;
  assign out_valid = fsm == DONE;
  assign busy = fsm != IDLE;
  assign plain = st;
  always_comb begin
    fsmNext = fsm;
    case (fsm)
      IDLE:    fsmNext = in_valid ? (cacheHit ? ADDK : KEYEXP) : IDLE;
      KEYEXP:  fsmNext = cnt == 4'(NR) ? ADDK : KEYEXP;
      ADDK:    fsmNext = ROUND;
      ROUND:   fsmNext = cnt == 4'd0 ? DONE : ROUND;
      DONE:    fsmNext = out_ready ? IDLE : DONE;
      default: fsmNext = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
      cnt <= '0;
      st <= '0;
      rk <= '{default: '0};
    end else begin
      fsm <= fsmNext;
      case (fsm)
        IDLE: if (in_valid) begin
          st <= cipher;
          rk[0] <= key;
          cnt <= 4'd1;
        end
        KEYEXP: begin
          rk[cnt] <= keyExpand(rk[cnt-4'd1], RCON[cnt]);
          cnt <= cnt + 4'd1;
        end
        ADDK: begin
          st <= st ^ rk[NR];
          cnt <= 4'(NR - 1);
        end
        ROUND: begin
          st <= roundOut;
          cnt <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end
`ifdef AES_DEC_KEY_CACHE_EN
  logic [32*NK-1:0] cacheKey;
  logic cacheValid;
  // the round-key file still holds the schedule of cacheKey, so a hit can go straight to ADDK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cacheKey <= '0;
      cacheValid <= 1'b0;
    end else if (fsm == KEYEXP && cnt == 4'(NR)) begin
      cacheKey <= rk[0];
      cacheValid <= 1'b1;
    end
  end
  assign cacheHit = cacheValid && key == cacheKey;
`else
  assign cacheHit = 1'b0;
`endif
endmodule

// File: tb/tb_aes_128_decryptor_iter.sv
// tb_aes_128_decryptor_iter: directed FIPS-197 vectors with a scoreboard of expected plaintext and latency.
module tb_aes_128_decryptor_iter;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] key, cipher, plain;
  int checks = 0;
  int failures = 0;
  logic [127:0] sbPlain[$];
  int sbLat[$];
  logic [127:0] sbKey[$];
  bit cacheOk = 1'b0;
  logic [127:0] cachedKey = '0;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  aes_128_decryptor_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .cipher(cipher), .out_valid(out_valid), .out_ready(out_ready),
    .plain(plain), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic startJob(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    int lat;
    lat = 21;
`ifdef AES_DEC_KEY_CACHE_EN
    if (cacheOk && k == cachedKey) lat = 11;
`endif
    @(negedge clk);
    key = k;
    cipher = c;
    in_valid = 1'b1;
    sbPlain.push_back(p);
    sbLat.push_back(lat);
    sbKey.push_back(k);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    key = {4{$urandom}};
    cipher = {4{$urandom}};
    chk("accept_in_ready", {127'd0, in_ready}, 128'd0);
  endtask

  task automatic finishJob(input int hold, input bit garbage);
    int edges;
    logic [127:0] exp, k;
    int lat;
    edges = 0;
    exp = sbPlain.pop_front();
    lat = sbLat.pop_front();
    k = sbKey.pop_front();
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
      if (garbage && !out_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        key = {4{$urandom}};
        cipher = {4{$urandom}};
      end
    end
    in_valid = 1'b0;
    chk("latency", 128'(edges), 128'(lat));
    chk("plain", plain, exp);
    chk("done_in_ready", {127'd0, in_ready}, 128'd0);
    chk("done_busy", {127'd0, busy}, 128'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_plain", plain, exp);
      chk("hold_in_ready", {127'd0, in_ready}, 128'd0);
      chk("hold_out_valid", {127'd0, out_valid}, 128'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_in_ready", {127'd0, in_ready}, 128'd1);
    chk("post_out_valid", {127'd0, out_valid}, 128'd0);
    chk("post_plain", plain, exp);
    cacheOk = 1'b1;
    cachedKey = k;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    key = '0;
    cipher = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_plain", plain, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    startJob(K1, C1, P1);
    finishJob(0, 1'b0);
    startJob(K1, C1, P1);
    finishJob(0, 1'b0);
    startJob(K2, C2, P2);
    finishJob(5, 1'b0);
    startJob(K2, C2, P2);
    finishJob(0, 1'b1);
    startJob(K1, C1, P1);
    repeat (14) @(posedge clk);
    #1;
    chk("pre_reset_busy", {127'd0, busy}, 128'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_plain", plain, 128'd0);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("midrst_busy", {127'd0, busy}, 128'd0);
    void'(sbPlain.pop_front());
    void'(sbLat.pop_front());
    void'(sbKey.pop_front());
    cacheOk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    startJob(K1, C1, P1);
    finishJob(2, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_128_decryptor_iter.md
Name: aes_128_decryptor_iter

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 straight InvCipher): one round per clock.
- Decrypts one 128-bit ciphertext block under a 128-bit key and returns the 128-bit plaintext.
- Expands the key schedule internally, one round key per cycle, into an 11-entry round-key register file.
- Sits beside the combinational encryptor as its receiving-end counterpart; valid/ready handshake on both sides.

Parameters:
- NUM_ROUNDS, 10: cipher rounds. Only 10 is legal; any other value must fail elaboration.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  cipher/key presented.
- in_ready  output  1  block idle, accepts a new job.
- key  input  128  cipher key; bits [127:120] = byte 0.
- cipher  input  128  ciphertext; FIPS-197 byte order, column-major state.
- out_valid  output  1  plain holds a result.
- out_ready  input  1  consumer accepts the result.
- plain  output  128  plaintext.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - FSM goes to IDLE; in_ready=1, out_valid=0, busy=0, plain=0.
  - Round counter, state register, round keys and key-cache valid flag are cleared.
  - Reset mid-job abandons the job; no partial result ever appears.
- FSM states: IDLE, KEYEXP, ADDK, ROUND, DONE.
- IDLE:
  - in_ready=1. On in_valid&&in_ready, register cipher into the state register and key into RK0; cnt<=1.
  - Next state is KEYEXP.
- KEYEXP:
  - Each cycle computes RK[cnt] = expand(RK[cnt-1], rcon[cnt]) and increments cnt.
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - After RK10 is written (10 cycles), go to ADDK.
- ADDK: state <= state ^ RK10; cnt<=9; go to ROUND (1 cycle).
- ROUND:
  - Each cycle: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ RK[cnt]) for cnt 9..1.
  - When cnt==0: state <= InvSubBytes(InvShiftRows(state)) ^ RK0, with no InvMixColumns; go to DONE.
  - 10 cycles total.
- DONE:
  - out_valid=1; plain=state, held stable until out_ready.
  - On out_valid&&out_ready, return to IDLE on that edge. plain keeps its last value; out_valid drops.
- Latency: out_valid rises on the 21st rising edge after the accepting edge. Next accept is possible one cycle after the output handshake.
- No overlap: in_ready=0 outside IDLE. in_valid outside IDLE is ignored; cipher and key need not be held after acceptance.
- out_ready asserted early, before DONE, has no effect.
- Arithmetic:
  - GF(2^8) with polynomial 0x11b.
  - InvMixColumns coefficients 0e,0b,0d,09.
  - InvShiftRows rotates row r right by r.

Optional Feature:
- Macro: AES_DEC_KEY_CACHE_EN.
- Defined:
  - A stored copy of the last fully expanded key plus a valid flag is kept.
  - On accept, if key equals the cached key and the flag is set, KEYEXP is skipped (IDLE->ADDK); latency becomes 11 edges.
  - The flag is set on KEYEXP completion and cleared by reset.
  - A reset during KEYEXP leaves the flag clear.
- Undefined:
  - Every job runs KEYEXP; latency is always 21.
  - No cache registers exist.

Decomposition:
- Package aes_pkg holds:
  - sbox and inv_sbox functions;
  - rcon constant array;
  - xtime and gf_mul functions;
  - NB=4, NK=4, NR=10 constants;
  - FSM state enum.
- Natural sub-module: aes_inv_round. Combinational, inputs state, round_key and last_round flag; output next state.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> plain 00112233445566778899aabbccddeeff, out_valid at edge 21.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32 -> plain 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> plain stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge.
- Reset mid-ROUND (rst_n low at edge 15) -> out_valid=0, plain=0, in_ready=1 immediately. The C.1 job re-run afterwards passes.
- in_valid toggled with garbage during a job -> ignored; result unchanged.
- With AES_DEC_KEY_CACHE_EN: two back-to-back C.1 jobs -> second result at edge 11. A job with a different key -> edge 21 and correct plaintext.
